// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to resolve multiplies in one cycle with a combinational product.
module muldiv_unit #(
    parameter int MP_DATA_WIDTH = 32
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic                     iflush,
    input  logic                     ivalid,
    output logic                     oready,
    input  logic [2:0]               ictrl,
    input  logic [MP_DATA_WIDTH-1:0] isrc_a,
    input  logic [MP_DATA_WIDTH-1:0] isrc_b,
    output logic                     ovalid,
    input  logic                     iready,
    output logic [MP_DATA_WIDTH-1:0] oresult,
    output logic                     ozero,
    output logic                     onegative,
    output logic                     odiv_zero
);
    // state | meaning
    // IDLE  | waiting for a request, oready high
    // CALC  | one multiply/divide bit per cycle, W cycles
    // DONE  | result held with ovalid until iready
    localparam int W  = MP_DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic            neg_q;
    logic            rem_neg_q;
    logic [W-1:0]    acc_hi;
    logic [W-1:0]    acc_lo;
    logic [W-1:0]    mag_op;
    logic [CW-1:0]   count;

    logic            a_signed, b_signed, sa, sb;
    logic [W-1:0]    abs_a, abs_b;
    logic            in_div_zero, in_ovf;
    logic [W-1:0]    early_res;

    always_comb begin
        a_signed    = (ictrl == 3'd1) || (ictrl == 3'd2) || (ictrl == 3'd4) || (ictrl == 3'd6);
        b_signed    = (ictrl == 3'd1) || (ictrl == 3'd4) || (ictrl == 3'd6);
        sa          = a_signed & isrc_a[W-1];
        sb          = b_signed & isrc_b[W-1];
        abs_a       = sa ? -isrc_a : isrc_a;
        abs_b       = sb ? -isrc_b : isrc_b;
        in_div_zero = ictrl[2] & (isrc_b == '0);
        in_ovf      = ictrl[2] & ~ictrl[0] & (isrc_a == {1'b1, {(W-1){1'b0}}}) & (isrc_b == '1);
        if (in_div_zero)
            early_res = ictrl[1] ? isrc_a : '1;
        else
            early_res = ictrl[1] ? '0 : isrc_a;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0]  fast_prod, fast_signed;
    logic [W-1:0]    fast_res;

    always_comb begin
        fast_prod   = {{W{1'b0}}, abs_a} * {{W{1'b0}}, abs_b};
        fast_signed = (sa ^ sb) ? -fast_prod : fast_prod;
        fast_res    = (ictrl == 3'd0) ? fast_signed[W-1:0] : fast_signed[2*W-1:W];
    end
`endif

    // One iteration: shift-add for multiply, restoring subtract for divide.
    logic [W:0]      mul_sum, rem_sh, div_sub;
    logic [W-1:0]    step_hi, step_lo;
    logic [2*W-1:0]  prod, prod_s;
    logic [W-1:0]    calc_res;

    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_op} : {(W+1){1'b0}});
        rem_sh  = {acc_hi, acc_lo[W-1]};
        div_sub = rem_sh - {1'b0, mag_op};
        if (op_q[2]) begin
            step_hi = div_sub[W] ? rem_sh[W-1:0] : div_sub[W-1:0];
            step_lo = {acc_lo[W-2:0], ~div_sub[W]};
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], acc_lo[W-1:1]};
        end
        prod   = {step_hi, step_lo};
        prod_s = neg_q ? -prod : prod;
        case (op_q)
            3'd0:       calc_res = prod_s[W-1:0];
            3'd1, 3'd2,
            3'd3:       calc_res = prod_s[2*W-1:W];
            3'd4, 3'd5: calc_res = neg_q ? -step_lo : step_lo;
            default:    calc_res = rem_neg_q ? -step_hi : step_hi;
        endcase
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state     <= IDLE;
            oready    <= 1'b1;
            ovalid    <= 1'b0;
            oresult   <= '0;
            odiv_zero <= 1'b0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            mag_op    <= '0;
            count     <= '0;
        end else if (iflush) begin
            state  <= IDLE;
            oready <= 1'b1;
            ovalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ivalid && oready) begin
                        op_q      <= ictrl;
                        neg_q     <= sa ^ sb;
                        rem_neg_q <= sa;
                        acc_hi    <= '0;
                        acc_lo    <= ictrl[2] ? abs_a : abs_b;
                        mag_op    <= ictrl[2] ? abs_b : abs_a;
                        count     <= '0;
                        oready    <= 1'b0;
                        if (in_div_zero || in_ovf) begin
                            state     <= DONE;
                            oresult   <= early_res;
                            odiv_zero <= in_div_zero;
                            ovalid    <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!ictrl[2]) begin
                            state     <= DONE;
                            oresult   <= fast_res;
                            odiv_zero <= 1'b0;
                            ovalid    <= 1'b1;
`endif
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + 1'b1;
                    if (count == CW'(W-1)) begin
                        state     <= DONE;
                        oresult   <= calc_res;
                        odiv_zero <= 1'b0;
                        ovalid    <= 1'b1;
                    end
                end
                DONE: begin
                    if (iready) begin
                        state  <= IDLE;
                        ovalid <= 1'b0;
                        oready <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ovalid <= 1'b0;
                    oready <= 1'b1;
                end
            endcase
        end
    end

    assign ozero     = (oresult == '0);
    assign onegative = oresult[W-1];

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic          iclk = 1'b0;
    logic          irst, iflush, ivalid, iready;
    logic          oready, ovalid, ozero, onegative, odiv_zero;
    logic [2:0]    ictrl;
    logic [W-1:0]  isrc_a, isrc_b, oresult;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] last_res;

    muldiv_unit #(.MP_DATA_WIDTH(W)) dut (
        .iclk(iclk), .irst(irst), .iflush(iflush), .ivalid(ivalid), .oready(oready),
        .ictrl(ictrl), .isrc_a(isrc_a), .isrc_b(isrc_b), .ovalid(ovalid), .iready(iready),
        .oresult(oresult), .ozero(ozero), .onegative(onegative), .odiv_zero(odiv_zero)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input int hold);
        int   exp_lat, cyc;
        logic exp_dz;
        exp_dz  = op[2] && (b == 0);
        exp_lat = W + 1;
        if (op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            exp_lat = 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) exp_lat = 1;
`endif
        @(negedge iclk);
        check({tag, "_ready_in"}, 64'(oready), 64'd1);
        ivalid = 1'b1; ictrl = op; isrc_a = a; isrc_b = b;
        @(posedge iclk);
        cyc = 0;
        do begin
            @(negedge iclk);
            cyc++;
            if (cyc == 1) begin
                check({tag, "_busy"}, 64'(oready), 64'd0);
                ivalid = 1'b0;
                ictrl  = 3'($urandom);
                isrc_a = $urandom;
                isrc_b = $urandom;
            end
        end while (!ovalid && cyc < 100);
        check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_result"}, 64'(oresult), 64'(exp_r));
        check({tag, "_zero"}, 64'(ozero), 64'(exp_r == 0));
        check({tag, "_neg"}, 64'(onegative), 64'(exp_r[31]));
        check({tag, "_divzero"}, 64'(odiv_zero), 64'(exp_dz));
        for (int i = 0; i < hold; i++) begin
            ivalid = 1'b1;
            ictrl  = 3'($urandom);
            isrc_a = $urandom;
            isrc_b = $urandom;
            @(negedge iclk);
            check({tag, "_hold_valid"}, 64'(ovalid), 64'd1);
            check({tag, "_hold_result"}, 64'(oresult), 64'(exp_r));
        end
        ivalid = 1'b0;
        iready = 1'b1;
        @(negedge iclk);
        check({tag, "_release"}, 64'({ovalid, oready}), 64'd1);
        iready   = 1'b0;
        last_res = exp_r;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        saw_valid;
        irst = 1'b0; iflush = 1'b0; ivalid = 1'b0; iready = 1'b0;
        ictrl = '0; isrc_a = '0; isrc_b = '0;
        #1 irst = 1'b1;
        repeat (2) @(negedge iclk);
        check("rst_ready", 64'(oready), 64'd1);
        check("rst_valid", 64'(ovalid), 64'd0);
        check("rst_result", 64'(oresult), 64'd0);
        check("rst_flags", 64'({ozero, onegative, odiv_zero}), 64'b100);
        irst = 1'b0;

        run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
        run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
        run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
        run_op("divu",   3'd5, 32'd100,        32'd7,         32'd14, 0);
        run_op("remu",   3'd7, 32'd100,        32'd7,         32'd2, 0);
        run_op("divu0",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run_op("rem0",   3'd6, 32'd5,          32'd0,         32'd5, 0);
        run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0, 0);
        run_op("bp",     3'd5, 32'd1000,       32'd3,         32'd333, 10);

        // Flush in the middle of a divide.
        @(negedge iclk);
        ivalid = 1'b1; ictrl = 3'd4; isrc_a = 32'd1234; isrc_b = 32'd7;
        @(negedge iclk);
        ivalid = 1'b0;
        repeat (4) @(negedge iclk);
        iflush = 1'b1;
        @(negedge iclk);
        iflush = 1'b0;
        check("flush_state", 64'({ovalid, oready}), 64'd1);
        check("flush_result", 64'(oresult), 64'(last_res));
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge iclk);
            saw_valid = saw_valid | ovalid;
        end
        check("flush_no_valid", 64'(saw_valid), 64'd0);

        // Flush together with a request drops the request.
        iflush = 1'b1; ivalid = 1'b1; ictrl = 3'd5; isrc_a = 32'd9; isrc_b = 32'd3;
        @(negedge iclk);
        iflush = 1'b0; ivalid = 1'b0;
        @(negedge iclk);
        check("flush_drop", 64'({ovalid, oready}), 64'd1);

        // Async reset mid-divide.
        ivalid = 1'b1; ictrl = 3'd5; isrc_a = 32'd77777; isrc_b = 32'd13;
        @(negedge iclk);
        ivalid = 1'b0;
        repeat (10) @(negedge iclk);
        irst = 1'b1;
        #1;
        check("arst_state", 64'({ovalid, oready}), 64'd1);
        check("arst_result", 64'(oresult), 64'd0);
        check("arst_zero", 64'(ozero), 64'd1);
        @(negedge iclk);
        irst = 1'b0;
        run_op("post_rst", 3'd5, 32'd77777, 32'd13, 32'd5982, 0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($signed($urandom_range(0, 200)) - 100); b = 32'($signed($urandom_range(0, 20)) - 10); end
                3: b = $urandom_range(1, 255);
                default: ;
            endcase
            run_op("rand", op, a, b, model(op, a, b), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
